// File: rtl/core_types_pkg.sv
// Shared fetch-predictor types and sizing.
// Holds the upper-PC table geometry defaults, the update-outcome enum and the
// lowest-set-bit priority encoder used for first-match / first-free search.
package core_types_pkg;

  localparam int BTB_TARGET_WIDTH  = 11;
  localparam int UPCT_ENTRIES      = 8;
  localparam int LOG_UPCT_ENTRIES  = $clog2(UPCT_ENTRIES);
  localparam int UPPER_PC_WIDTH    = 32 - BTB_TARGET_WIDTH - 1;
  localparam int MAX_UPCT_ENTRIES  = 64;

  // How an update request chose its entry.
  typedef enum logic [1:0] {
    UPD_HIT   = 2'd0,  // value already present
    UPD_FILL  = 2'd1,  // miss, took the lowest invalid entry
    UPD_EVICT = 2'd2,  // miss, table full, took the PLRU victim
    UPD_FLUSH = 2'd3   // invalidate in same cycle: empty table, entry 0
  } upd_kind_e;

  // Index of the lowest set bit; 0 when the vector is empty (callers
  // check for an empty vector separately).
  function automatic logic [5:0] lowest_set(input logic [MAX_UPCT_ENTRIES-1:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int i = MAX_UPCT_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/upct_plru_if.sv
// Request/response bundle of the upper-PC table.
// master: predictor/update side driving requests and receiving responses.
// slave : the table itself.
interface upct_plru_if #(
  parameter int UPCT_ENTRIES     = core_types_pkg::UPCT_ENTRIES,
  parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
  parameter int UPPER_PC_WIDTH   = core_types_pkg::UPPER_PC_WIDTH
);
  logic                        read_valid_REQ;
  logic [LOG_UPCT_ENTRIES-1:0] read_index_REQ;
  logic [UPPER_PC_WIDTH-1:0]   read_upper_PC_RESP;
  logic                        update0_valid;
  logic [UPPER_PC_WIDTH-1:0]   update0_upper_PC;
  logic                        update1_valid;
  logic                        update1_hit;
  logic [LOG_UPCT_ENTRIES-1:0] update1_upper_PC_index;
  logic                        invalidate_all;

  modport master (
    output read_valid_REQ, read_index_REQ, update0_valid, update0_upper_PC, invalidate_all,
    input  read_upper_PC_RESP, update1_valid, update1_hit, update1_upper_PC_index
  );

  modport slave (
    input  read_valid_REQ, read_index_REQ, update0_valid, update0_upper_PC, invalidate_all,
    output read_upper_PC_RESP, update1_valid, update1_hit, update1_upper_PC_index
  );
endinterface

// File: rtl/upct_plru_plru_updater.sv
// Combinational tree-PLRU helper.
// bits_in/touch_index -> bits_out : node bits after touching one leaf.
// bits_in             -> victim_index : leaf reached by following node bits.
// Nodes are stored heap-ordered: node n has children 2n+1 (lower) and 2n+2.
// A node bit of 0 points at the lower-index subtree.
module plru_updater #(
  parameter int NUM_ENTRIES = 8,
  parameter int LOG_ENTRIES = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-2:0] bits_in,
  input  logic [LOG_ENTRIES-1:0] touch_index,
  output logic [NUM_ENTRIES-2:0] bits_out,
  output logic [LOG_ENTRIES-1:0] victim_index
);
  localparam int NODE_W = (NUM_ENTRIES > 2) ? $clog2(NUM_ENTRIES - 1) : 1;

  // Each node knows statically its level and position in that level, so it
  // can tell whether it sits on the path to the touched leaf.
  for (genvar gi = 0; gi < NUM_ENTRIES - 1; gi++) begin : g_node
    localparam int LVL = $clog2(gi + 2) - 1;
    localparam int POS = gi + 1 - (1 << LVL);
    logic on_path;
    assign on_path      = ((int'(touch_index) >> (LOG_ENTRIES - LVL)) == POS);
    assign bits_out[gi] = on_path ? ~touch_index[LOG_ENTRIES-1-LVL] : bits_in[gi];
  end

  logic [LOG_ENTRIES-1:0] victim_acc;
  logic                   step;
  int                     node;

  always_comb begin
    victim_acc = '0;
    step       = 1'b0;
    node       = 0;
    for (int lvl = 0; lvl < LOG_ENTRIES; lvl++) begin
      step       = bits_in[NODE_W'(node)];
      victim_acc = (victim_acc << 1) | LOG_ENTRIES'(step);
      node       = 2 * node + (step ? 2 : 1);
    end
  end

  assign victim_index = victim_acc;
endmodule

// File: rtl/upct_plru.sv
// Upper-PC table with tree-PLRU replacement.
// CLK/nRST : clock, synchronous active-low reset.
// bus      : read-by-index (1-cycle), find-or-insert update (1-cycle
//            response), whole-table invalidate.
module upct_plru #(
  parameter int UPCT_ENTRIES     = core_types_pkg::UPCT_ENTRIES,
  parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
  parameter int UPPER_PC_WIDTH   = core_types_pkg::UPPER_PC_WIDTH
) (
  input  logic       CLK,
  input  logic       nRST,
  upct_plru_if.slave bus
);
  import core_types_pkg::*;

  localparam int N = UPCT_ENTRIES;

  logic [UPPER_PC_WIDTH-1:0]   upper_pc_q [N];
  logic [UPPER_PC_WIDTH-1:0]   upper_pc_d [N];
  logic [N-1:0]                valid_q, valid_d;
  logic [N-2:0]                plru_q, plru_d;
  logic [UPPER_PC_WIDTH-1:0]   read_resp_q, read_resp_d;
  logic                        upd_valid_q, upd_valid_d;
  logic                        upd_hit_q, upd_hit_d;
  logic [LOG_UPCT_ENTRIES-1:0] upd_index_q, upd_index_d;

  logic [N-1:0]                match_vec, entry_write;
  logic [N-2:0]                plru_rd_touched, plru_after_read, plru_upd_touched;
  logic [LOG_UPCT_ENTRIES-1:0] victim_idx, upd_victim_unused, upd_sel;
  upd_kind_e                   upd_kind;

  // The victim comes from the state at the start of the cycle, so a read in
  // the same cycle cannot steer the replacement away from its own entry.
  plru_updater #(.NUM_ENTRIES(N)) u_read_touch (
    .bits_in      (plru_q),
    .touch_index  (bus.read_index_REQ),
    .bits_out     (plru_rd_touched),
    .victim_index (victim_idx)
  );

  // Invalidate discards the read touch and restarts from all-zero bits.
  assign plru_after_read = bus.invalidate_all ? '0 :
                           bus.read_valid_REQ ? plru_rd_touched : plru_q;

  plru_updater #(.NUM_ENTRIES(N)) u_update_touch (
    .bits_in      (plru_after_read),
    .touch_index  (upd_sel),
    .bits_out     (plru_upd_touched),
    .victim_index (upd_victim_unused)
  );

  always_comb begin
    upd_kind = UPD_EVICT;
    upd_sel  = victim_idx;
    if (bus.invalidate_all) begin
      upd_kind = UPD_FLUSH;
      upd_sel  = '0;
    end else if (|match_vec) begin
      upd_kind = UPD_HIT;
      upd_sel  = LOG_UPCT_ENTRIES'(lowest_set(MAX_UPCT_ENTRIES'(match_vec)));
    end else if (~&valid_q) begin
      upd_kind = UPD_FILL;
      upd_sel  = LOG_UPCT_ENTRIES'(lowest_set(MAX_UPCT_ENTRIES'(~valid_q)));
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    assign match_vec[gi]   = valid_q[gi] && (upper_pc_q[gi] == bus.update0_upper_PC);
    assign entry_write[gi] = bus.update0_valid && (upd_kind != UPD_HIT) &&
                             (upd_sel == LOG_UPCT_ENTRIES'(gi));
    assign upper_pc_d[gi]  = entry_write[gi] ? bus.update0_upper_PC : upper_pc_q[gi];
    assign valid_d[gi]     = entry_write[gi] || (valid_q[gi] && !bus.invalidate_all);

    always_ff @(posedge CLK) begin
      if (!nRST) upper_pc_q[gi] <= '0;
      else       upper_pc_q[gi] <= upper_pc_d[gi];
    end
  end

  always_comb begin
    plru_d      = plru_after_read;
    read_resp_d = read_resp_q;
    upd_valid_d = bus.update0_valid;
    upd_hit_d   = upd_hit_q;
    upd_index_d = upd_index_q;
    // The read sees the pre-write value even if the update writes that entry.
    if (bus.read_valid_REQ) read_resp_d = upper_pc_q[bus.read_index_REQ];
    if (bus.update0_valid) begin
      plru_d      = plru_upd_touched;
      upd_hit_d   = (upd_kind == UPD_HIT);
      upd_index_d = upd_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q     <= '0;
      plru_q      <= '0;
      read_resp_q <= '0;
      upd_valid_q <= 1'b0;
      upd_hit_q   <= 1'b0;
      upd_index_q <= '0;
    end else begin
      valid_q     <= valid_d;
      plru_q      <= plru_d;
      read_resp_q <= read_resp_d;
      upd_valid_q <= upd_valid_d;
      upd_hit_q   <= upd_hit_d;
      upd_index_q <= upd_index_d;
    end
  end

  assign bus.read_upper_PC_RESP     = read_resp_q;
  assign bus.update1_valid          = upd_valid_q;
  assign bus.update1_hit            = upd_hit_q;
  assign bus.update1_upper_PC_index = upd_index_q;
endmodule
